// File: rtl/line_buf_pkg.sv
// Shared types and sizing for the ping-pong line buffer controller.
// Bank lifecycle enum and default widths used by the controller, its interface and the bench.
package line_buf_pkg;

    localparam int ADDR_W_DEF   = 11;
    localparam int STRIDE_W_DEF = 3;
    localparam int FRAME_CNT_W  = 5;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    function automatic logic bank_writable(bank_state_t s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

    function automatic logic bank_readable(bank_state_t s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

endpackage

// File: rtl/line_buf_if.sv
// Write/read handshake and RAM-side strobes between the line buffer controller and its environment.
// The controller is the slave; whoever drives wr_valid/rd_ready is the master.
interface line_buf_if
    import line_buf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_ready;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;

    modport slave (
        input  wr_valid, rd_ready,
        output wr_ready, wr_en, wr_bank, wr_addr,
        output rd_en, rd_bank, rd_addr, rd_valid
    );

    modport master (
        output wr_valid, rd_ready,
        input  wr_ready, wr_en, wr_bank, wr_addr,
        input  rd_en, rd_bank, rd_addr, rd_valid
    );
endinterface

// File: rtl/stride_addr_gen.sv
// Interleaved write address generator: addr = stride*index + phase, phase-major order.
// Index is the low-order counter, so the natural wrap of both fields clears them after the last word.
module stride_addr_gen
    import line_buf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int STRIDE_W = STRIDE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam int IDX_W = ADDR_W - STRIDE_W;

    logic [STRIDE_W-1:0] phase_q;
    logic [IDX_W-1:0]    idx_q;

    assign addr = {idx_q, phase_q};
    assign last = (&phase_q) & (&idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            idx_q   <= '0;
        end else if (en) begin
            idx_q <= idx_q + 1'b1;
            if (&idx_q) begin
                phase_q <= phase_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Two-bank ping-pong line buffer controller: interleaved fill on one bank, linear drain of the other.
// state         | meaning
// BANK_EMPTY    | no valid data, writable
// BANK_FILLING  | partially written, writer owns it
// BANK_FULL     | complete frame, waiting for the reader
// BANK_DRAINING | reader has started, not writable until fully read
module line_buf_ctrl
    import line_buf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int STRIDE_W = STRIDE_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    line_buf_if.slave              bus,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    bank_state_t            bank_st  [2];
    bank_state_t            bank_nxt [2];
    logic                   wr_bank_q;
    logic                   rd_bank_q;
    logic                   run_q;
    logic                   rd_valid_q;
    logic [ADDR_W-1:0]      rd_addr_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [ADDR_W-1:0]      gen_addr;
    logic                   gen_last;
    logic                   wr_ready;
    logic                   wr_en;
    logic                   rd_en;
    logic                   wr_last;
    logic                   rd_last;

    stride_addr_gen #(
        .ADDR_W   (ADDR_W),
        .STRIDE_W (STRIDE_W)
    ) u_wr_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_en),
        .addr  (gen_addr),
        .last  (gen_last)
    );

    // run_q keeps the writer closed while reset is held and opens it on the first edge after release
    assign wr_ready = run_q & bank_writable(bank_st[wr_bank_q]);
    assign wr_en    = bus.wr_valid & wr_ready;
    assign rd_en    = bus.rd_ready & bank_readable(bank_st[rd_bank_q]);
    assign wr_last  = wr_en & gen_last;
    assign rd_last  = rd_en & (&rd_addr_q);

    assign bus.wr_ready = wr_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_bank  = wr_bank_q;
    assign bus.wr_addr  = gen_addr;
    assign bus.rd_en    = rd_en;
    assign bus.rd_bank  = rd_bank_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_valid = rd_valid_q;
    assign frame_cnt    = frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
        end else begin
            bank_st[0] <= bank_nxt[0];
            bank_st[1] <= bank_nxt[1];
        end
    end

    // Writer and reader never own the same bank, so both updates can land in one cycle
    always_comb begin
        bank_nxt[0] = bank_st[0];
        bank_nxt[1] = bank_st[1];
        for (int b = 0; b < 2; b++) begin
            if (wr_en && (wr_bank_q == 1'(b))) begin
                bank_nxt[b] = wr_last ? BANK_FULL : BANK_FILLING;
            end
            if (rd_en && (rd_bank_q == 1'(b))) begin
                bank_nxt[b] = rd_last ? BANK_EMPTY : BANK_DRAINING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            run_q      <= 1'b1;
            rd_valid_q <= rd_en;
            if (wr_last) begin
                wr_bank_q   <= ~wr_bank_q;
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (rd_en) begin
                rd_addr_q <= rd_addr_q + 1'b1;
            end
            if (rd_last) begin
                rd_bank_q <= ~rd_bank_q;
            end
        end
    end

endmodule
